mole_button_conditioner: RTL
============================

Name: mole_button_conditioner

Overview:
Front end for the eight whack sensors and buttons. It synchronizes and debounces the raw pins and produces clean press levels for the register file's JA input. It also classifies each press against the active-mole bits (the register file's JB output) as a hit or a miss. Sticky hit/miss flags and a saturating hit counter are kept for the game loop to poll and clear.

Parameters:
N_CH, 8, number of button channels (fixed 8 to match JA/JB)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (5 ms at 100 MHz)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
HIT_W, 8, hit counter width

Ports:
clock  input  1  system clock, rising edge
ctrl_reset_n  input  1  asynchronous, active-low reset
btn_raw  input  N_CH  raw physical button pins, asynchronous to clock
mole_active  input  N_CH  active-mole bits (JB from the register file)
flags_clear  input  1  one-cycle pulse; clears hit_flags and miss_flags
count_clear  input  1  one-cycle pulse; clears hit_count
btn_clean  output  N_CH  debounced press level, 1 = pressed (drives the register file's JA)
press_pulse  output  N_CH  one-cycle pulse on each debounced rising edge
hit_flags  output  N_CH  sticky; bit i set when a press on i coincides with mole_active[i]=1
miss_flags  output  N_CH  sticky; bit i set when a press on i coincides with mole_active[i]=0
hit_count  output  HIT_W  saturating count of hits since the last clear

Behaviour:
- Reset (ctrl_reset_n=0) is asynchronous. On reset:
  - all outputs = 0
  - synchronizer flops = released level
  - debounce counters = 0
  - per-channel FSMs = RELEASED
- Synchronizer: 2 flops per channel. The synced value is used only after the second flop.
- Per-channel FSM, 2 states (RELEASED, PRESSED), plus a CNT_W counter:
  - While synced equals the current state level, the counter is held at 0.
  - While synced differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while synced still differs, the state toggles and the counter returns to 0.
  - Any cycle where synced matches the state again resets the counter; glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: for a raw change held steadily, btn_clean changes DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new value.
- btn_clean[i] = 1 iff the FSM is in PRESSED. It is registered with no combinational path from btn_raw.
- press_pulse[i] is high for exactly the one cycle in which btn_clean[i] goes 0->1. Releases produce no pulse.
- Classification uses mole_active sampled in the same cycle as press_pulse:
  - press & mole_active: set hit_flags[i]
  - press & ~mole_active: set miss_flags[i]
  - Flags are visible the cycle after the pulse.
- hit_count adds popcount(press_pulse & mole_active) each cycle and saturates at 2^HIT_W-1. Wrap-around is forbidden.
- Simultaneous flags_clear and a new set in the same cycle: the new set wins (bit reads 1 afterwards); all other bits clear.
- Simultaneous count_clear and hits in the same cycle: the result equals the number of hits in that cycle.
- mole_active changing during the debounce window has no effect; only its value at the pulse cycle matters.
- Multiple channels may pulse in the same cycle. Each is classified independently.

Optional Feature:
MOLE_BTN_INVERT_EN:
- Defined: btn_raw is active-low (pull-up pins). Data is inverted after the second synchronizer flop, and the synchronizer flops reset to 1.
- Undefined: btn_raw is active-high, and the synchronizer flops reset to 0.
- btn_clean and all downstream logic are identical in both builds.

Decomposition:
- Package mole_io_pkg holds:
  - N_CH = 8
  - DEBOUNCE_CYCLES default
  - CNT_W and HIT_W
  - the state encoding constants RELEASED = 0 and PRESSED = 1
- Sub-module btn_debounce_ch, instantiated N_CH times, contains synchronizer + counter + FSM + rising-edge pulse. It outputs clean and pulse.
- Classification, flags and hit counter stay in the top.

Test Plan:
(All tests use DEBOUNCE_CYCLES=4.)
- Clean press: btn_raw[3] 0->1 and held -> btn_clean[3]=1 exactly 6 edges after the first sampling edge; press_pulse[3] high one cycle; no other bits change.
- Glitch rejection: btn_raw[5] high for 3 cycles then low -> btn_clean and press_pulse stay 0, counter returns to 0. A 4-cycle-stable pulse is accepted.
- Hit vs miss: mole_active=8'h08, press ch3 -> hit_flags=8'h08, hit_count=1. Then mole_active=8'h00, press ch0 -> miss_flags=8'h01, hit_count=1.
- Clear collision: flags_clear pulses in the same cycle as a new hit pulse on ch1 while hit_flags=8'h08 -> hit_flags=8'h02 afterwards.
- Saturation and same-cycle count_clear: 260 hits -> hit_count=255. count_clear together with a 2-channel simultaneous hit -> hit_count=2.
- Reset mid-debounce: drop ctrl_reset_n for 1 cycle with counter at 2 and btn_clean=8'hFF -> all outputs 0 immediately (asynchronous). After release, re-debounce takes the full 6 edges.

Source files
------------

// File: rtl/mole_io_pkg.sv
// ---------------------------------------------------------------------------
// mole_io_pkg
// Shared constants for the mole button front end: channel count, default
// debounce length, counter widths, the two-state debounce encoding and the
// synchronizer reset level.
// Build option: MOLE_BTN_INVERT_EN selects active-low (pull-up) button pins.
// ---------------------------------------------------------------------------
package mole_io_pkg;

    localparam int unsigned N_CH            = 8;
    localparam int unsigned DEBOUNCE_CYCLES = 500000;
    localparam int unsigned CNT_W           = 20;
    localparam int unsigned HIT_W           = 8;
    localparam int unsigned PC_W            = $clog2(N_CH + 1);

    // Debounce FSM state encoding
    localparam logic [0:0] RELEASED = 1'b0;
    localparam logic [0:0] PRESSED  = 1'b1;

    // Synchronizer flops reset to the electrical "released" level of the pin
`ifdef MOLE_BTN_INVERT_EN
    localparam logic SYNC_RST_LVL = 1'b1;
`else
    localparam logic SYNC_RST_LVL = 1'b0;
`endif

    function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchronizer, debounce counter + 2-state FSM,
// registered clean level and a one-cycle pulse on each accepted press.
// Build option: MOLE_BTN_INVERT_EN inverts the pin after the second flop.
// Ports:
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous active-low reset
//   raw_i    raw button pin (asynchronous to clk_i)
//   clean_o  debounced level, 1 = pressed
//   pulse_o  one-cycle pulse coincident with clean_o rising
// ---------------------------------------------------------------------------
module btn_debounce_ch
    import mole_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = mole_io_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = mole_io_pkg::CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic clean_o,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             synced;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= SYNC_RST_LVL;
            sync2_q <= SYNC_RST_LVL;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MOLE_BTN_INVERT_EN
    assign synced = ~sync2_q;
`else
    assign synced = sync2_q;
`endif

    // Counter only runs while the synced level disagrees with the state;
    // any agreeing cycle drops it back to zero, rejecting short glitches.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (synced != state_q[0]) begin
            if (cnt_q == CNT_LAST) begin
                state_d = (state_q == PRESSED) ? RELEASED : PRESSED;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // clean/pulse are registered from the state so the pulse lines up
    // exactly with the 0->1 edge of the clean level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= (state_q == PRESSED);
            pulse_q <= (state_q == PRESSED) && !clean_q;
        end
    end

    assign clean_o = clean_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/mole_button_conditioner.sv
// ---------------------------------------------------------------------------
// mole_button_conditioner
// Debounces the eight whack buttons and classifies each press against the
// active-mole bits as hit or miss; keeps sticky flags and a saturating
// hit counter for the game loop.
// Build option: MOLE_BTN_INVERT_EN (active-low button pins).
// Ports:
//   clock        system clock, rising edge
//   ctrl_reset_n asynchronous active-low reset
//   btn_raw      raw button pins
//   mole_active  active-mole bits, sampled in the press-pulse cycle
//   flags_clear  pulse: clear hit_flags/miss_flags (new sets win)
//   count_clear  pulse: clear hit_count (same-cycle hits still counted)
//   btn_clean    debounced press level
//   press_pulse  one-cycle pulse per debounced press
//   hit_flags    sticky hit bits
//   miss_flags   sticky miss bits
//   hit_count    saturating hit count
// ---------------------------------------------------------------------------
module mole_button_conditioner
    import mole_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = mole_io_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = mole_io_pkg::CNT_W,
    parameter int unsigned HIT_W           = mole_io_pkg::HIT_W
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic [N_CH-1:0]  btn_raw,
    input  logic [N_CH-1:0]  mole_active,
    input  logic             flags_clear,
    input  logic             count_clear,
    output logic [N_CH-1:0]  btn_clean,
    output logic [N_CH-1:0]  press_pulse,
    output logic [N_CH-1:0]  hit_flags,
    output logic [N_CH-1:0]  miss_flags,
    output logic [HIT_W-1:0] hit_count
);

    logic [N_CH-1:0]  clean, pulse;
    logic [N_CH-1:0]  hit_set, miss_set;
    logic [N_CH-1:0]  hit_flags_q, hit_flags_d;
    logic [N_CH-1:0]  miss_flags_q, miss_flags_d;
    logic [HIT_W-1:0] hit_count_q, hit_count_d;
    logic [HIT_W-1:0] cnt_base;
    logic [HIT_W:0]   cnt_sum;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_i   (clock),
            .rst_ni  (ctrl_reset_n),
            .raw_i   (btn_raw[g]),
            .clean_o (clean[g]),
            .pulse_o (pulse[g])
        );
    end

    always_comb begin
        hit_set      = pulse & mole_active;
        miss_set     = pulse & ~mole_active;
        hit_flags_d  = (flags_clear ? '0 : hit_flags_q)  | hit_set;
        miss_flags_d = (flags_clear ? '0 : miss_flags_q) | miss_set;
        cnt_base     = count_clear ? '0 : hit_count_q;
        // One spare bit catches overflow so the count saturates instead of wrapping.
        cnt_sum      = {1'b0, cnt_base} + (HIT_W+1)'(popcount(hit_set));
        hit_count_d  = cnt_sum[HIT_W] ? '1 : cnt_sum[HIT_W-1:0];
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            hit_flags_q  <= '0;
            miss_flags_q <= '0;
            hit_count_q  <= '0;
        end else begin
            hit_flags_q  <= hit_flags_d;
            miss_flags_q <= miss_flags_d;
            hit_count_q  <= hit_count_d;
        end
    end

    assign btn_clean   = clean;
    assign press_pulse = pulse;
    assign hit_flags   = hit_flags_q;
    assign miss_flags  = miss_flags_q;
    assign hit_count   = hit_count_q;

endmodule
